// File: rtl/dmem_bank.sv
// Byte-addressed data memory: port A CPU load/store with lane enables, sub-word extension and error reporting; port B word read.
// Latency: port A response and port B read data are both registered, one cycle after the request/address.
// Backpressure: none; port A accepts a request every cycle and port B reads every cycle.
//
// Ports:
//   clk, rstn                          clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata/a_mode   port A request (byte address, store data, access mode)
//   a_rsp_valid/a_rdata/a_rsp_err      port A response, one cycle after a_req
//   b_addr/b_rdata                     port B word-indexed read, one-cycle latency
//   err_flag/err_addr/err_cnt          sticky error flag, first error address, saturating error count
module dmem_bank #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4096,
    parameter int ADDR_W   = 15,
    parameter int ERRCNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [ADDR_W-1:0]        a_addr,
    input  logic [DATA_W-1:0]        a_wdata,
    input  logic [2:0]               a_mode,
    output logic                     a_rsp_valid,
    output logic [DATA_W-1:0]        a_rdata,
    output logic                     a_rsp_err,
    input  logic [$clog2(DEPTH)-1:0] b_addr,
    output logic [DATA_W-1:0]        b_rdata,
    output logic                     err_flag,
    output logic [ADDR_W-1:0]        err_addr,
    output logic [ERRCNT_W-1:0]      err_cnt
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int WIDX_W = ADDR_W - LANE_W;

    localparam logic [2:0] M_WORD   = 3'd0;
    localparam logic [2:0] M_HALF   = 3'd1;
    localparam logic [2:0] M_HALF_U = 3'd2;
    localparam logic [2:0] M_BYTE   = 3'd3;
    localparam logic [2:0] M_BYTE_U = 3'd4;

    logic [DATA_W-1:0] ram [DEPTH];

    logic [LANE_W-1:0] a_lane;
    logic [IDX_W-1:0]  a_idx;
    logic              range_err;
    logic              acc_err;
    logic              store_ok;
    logic              load_ok;
    logic [LANES-1:0]  wr_be;
    logic [DATA_W-1:0] wr_dat;

    assign a_lane = a_addr[LANE_W-1:0];
    assign a_idx  = a_addr[LANE_W +: IDX_W];

    // Any set bit above the RAM index means the word index is >= DEPTH.
    generate
        if (WIDX_W > IDX_W) begin : g_range
            assign range_err = |a_addr[ADDR_W-1:LANE_W+IDX_W];
        end else begin : g_norange
            assign range_err = 1'b0;
        end
    endgenerate

    // All error causes lead to the same response, so their priority is irrelevant here.
    assign acc_err = (a_mode > M_BYTE_U)
                   | ((a_mode == M_WORD) && (a_lane != '0))
                   | (((a_mode == M_HALF) || (a_mode == M_HALF_U)) && a_addr[0])
                   | range_err
                   | (a_we && ((a_mode == M_HALF_U) || (a_mode == M_BYTE_U)));

    assign store_ok = a_req &  a_we & ~acc_err;
    assign load_ok  = a_req & ~a_we & ~acc_err;

    // Lane enables and lane-aligned store data; sub-word data is replicated so each lane picks its byte.
    always_comb begin
        wr_be  = '0;
        wr_dat = '0;
        for (int l = 0; l < LANES; l++) begin
            case (a_mode)
                M_WORD: begin
                    wr_be[l]        = 1'b1;
                    wr_dat[l*8 +: 8] = a_wdata[l*8 +: 8];
                end
                M_HALF: begin
                    wr_be[l]        = (int'(a_lane[LANE_W-1:1]) == l / 2);
                    wr_dat[l*8 +: 8] = (l % 2 == 1) ? a_wdata[15:8] : a_wdata[7:0];
                end
                M_BYTE: begin
                    wr_be[l]        = (int'(a_lane) == l);
                    wr_dat[l*8 +: 8] = a_wdata[7:0];
                end
                default: begin
                    wr_be[l]        = 1'b0;
                    wr_dat[l*8 +: 8] = 8'h00;
                end
            endcase
        end
    end

    // RAM contents survive reset; only lanes with an enable are written.
    always_ff @(posedge clk) begin
        if (store_ok) begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_be[l]) begin
                    ram[a_idx][l*8 +: 8] <= wr_dat[l*8 +: 8];
                end
            end
        end
    end

    logic                rsp_vld_q;
    logic                rsp_err_q;
    logic                ld_sel_q;
    logic [2:0]          ld_mode_q;
    logic [LANE_W-1:0]   ld_lane_q;
    logic [DATA_W-1:0]   ld_word_q;
    logic [DATA_W-1:0]   b_word_q;
    logic                err_flag_q, err_flag_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [ERRCNT_W-1:0] err_cnt_q,  err_cnt_d;

    always_comb begin
        err_flag_d = err_flag_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (a_req && acc_err) begin
            err_flag_d = 1'b1;
            if (!err_flag_q) begin
                err_addr_d = a_addr;
            end
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERRCNT_W'(1);
            end
        end
    end

    // Response fields only change when a request is accepted, so a_rdata/a_rsp_err hold between responses.
    // Port B reads with nonblocking semantics, so a same-cycle port A write is seen on the following read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_vld_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            ld_sel_q   <= 1'b0;
            ld_mode_q  <= M_WORD;
            ld_lane_q  <= '0;
            ld_word_q  <= '0;
            b_word_q   <= '0;
            err_flag_q <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            rsp_vld_q  <= a_req;
            err_flag_q <= err_flag_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
            b_word_q   <= ram[b_addr];
            if (a_req) begin
                rsp_err_q <= acc_err;
                ld_sel_q  <= load_ok;
            end
            if (load_ok) begin
                ld_word_q <= ram[a_idx];
                ld_mode_q <= a_mode;
                ld_lane_q <= a_lane;
            end
        end
    end

    // Extension uses the lane/mode captured with the read, not the current request.
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_ext;

    assign ld_byte = ld_word_q[{ld_lane_q, 3'b000} +: 8];
    assign ld_half = ld_word_q[{ld_lane_q[LANE_W-1:1], 4'b0000} +: 16];

    always_comb begin
        ld_ext = '0;
        case (ld_mode_q)
            M_WORD:   ld_ext = ld_word_q;
            M_HALF:   ld_ext = {{(DATA_W-16){ld_half[15]}}, ld_half};
            M_HALF_U: ld_ext = {{(DATA_W-16){1'b0}}, ld_half};
            M_BYTE:   ld_ext = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            M_BYTE_U: ld_ext = {{(DATA_W-8){1'b0}}, ld_byte};
            default:  ld_ext = '0;
        endcase
    end

    assign a_rsp_valid = rsp_vld_q;
    assign a_rsp_err   = rsp_err_q;
    assign a_rdata     = ld_sel_q ? ld_ext : '0;
    assign b_rdata     = b_word_q;
    assign err_flag    = err_flag_q;
    assign err_addr    = err_addr_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_dmem_bank.sv
// Bench for dmem_bank: byte-level memory model feeds a queue of expected responses.
// Latency: responses are compared one cycle after each request, sampled #1 after the clock edge.
// Backpressure: none; requests are issued back-to-back every cycle.
module tb_dmem_bank;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 4096;
    localparam int ADDR_W   = 15;
    localparam int ERRCNT_W = 8;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                a_req = 1'b0;
    logic                a_we = 1'b0;
    logic [ADDR_W-1:0]   a_addr = '0;
    logic [DATA_W-1:0]   a_wdata = '0;
    logic [2:0]          a_mode = '0;
    logic                a_rsp_valid;
    logic [DATA_W-1:0]   a_rdata;
    logic                a_rsp_err;
    logic [11:0]         b_addr = '0;
    logic [DATA_W-1:0]   b_rdata;
    logic                err_flag;
    logic [ADDR_W-1:0]   err_addr;
    logic [ERRCNT_W-1:0] err_cnt;

    always #5 clk = ~clk;

    dmem_bank #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ERRCNT_W(ERRCNT_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_mode(a_mode),
        .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata), .a_rsp_err(a_rsp_err),
        .b_addr(b_addr), .b_rdata(b_rdata),
        .err_flag(err_flag), .err_addr(err_addr), .err_cnt(err_cnt)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct packed {
        logic        we;
        logic [14:0] addr;
        logic [31:0] wd;
        logic [2:0]  mode;
    } vec_t;

    rsp_t        exp_q [$];
    logic [7:0]  mdl [DEPTH*4];
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_errs = 0;
    bit          have_err = 0;
    logic [14:0] first_err_addr = '0;

    // Drive one request and push the response the byte model predicts.
    task automatic drive(input vec_t v);
        rsp_t r;
        bit   err;
        int   a;
        a_req   = 1'b1;
        a_we    = v.we;
        a_addr  = v.addr;
        a_wdata = v.wd;
        a_mode  = v.mode;
        a = int'(v.addr);
        err = (v.mode > 3'd4) || (v.mode == 3'd0 && v.addr[1:0] != 2'b00)
           || ((v.mode == 3'd1 || v.mode == 3'd2) && v.addr[0])
           || (a >= DEPTH*4) || (v.we && (v.mode == 3'd2 || v.mode == 3'd4));
        r.err   = err;
        r.rdata = 32'h0;
        if (err) begin
            n_errs++;
            if (!have_err) begin
                have_err = 1;
                first_err_addr = v.addr;
            end
        end else if (v.we) begin
            case (v.mode)
                3'd0: for (int i = 0; i < 4; i++) mdl[a+i] = v.wd[8*i +: 8];
                3'd1: begin mdl[a] = v.wd[7:0]; mdl[a+1] = v.wd[15:8]; end
                default: mdl[a] = v.wd[7:0];
            endcase
        end else begin
            case (v.mode)
                3'd0: r.rdata = {mdl[a+3], mdl[a+2], mdl[a+1], mdl[a]};
                3'd1: r.rdata = {{16{mdl[a+1][7]}}, mdl[a+1], mdl[a]};
                3'd2: r.rdata = {16'h0, mdl[a+1], mdl[a]};
                3'd3: r.rdata = {{24{mdl[a][7]}}, mdl[a]};
                default: r.rdata = {24'h0, mdl[a]};
            endcase
        end
        exp_q.push_back(r);
    endtask

    task automatic idle();
        a_req = 1'b0;
        a_we  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_vec++; if (a_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset a_rsp_valid got %b want 0", a_rsp_valid); end
        n_vec++; if (a_rdata !== 32'h0) begin n_bad++; $display("FAIL reset a_rdata got %h want 0", a_rdata); end
        n_vec++; if (a_rsp_err !== 1'b0) begin n_bad++; $display("FAIL reset a_rsp_err got %b want 0", a_rsp_err); end
        n_vec++; if (b_rdata !== 32'h0) begin n_bad++; $display("FAIL reset b_rdata got %h want 0", b_rdata); end
        n_vec++; if (err_flag !== 1'b0) begin n_bad++; $display("FAIL reset err_flag got %b want 0", err_flag); end
        n_vec++; if (err_addr !== 15'h0) begin n_bad++; $display("FAIL reset err_addr got %h want 0", err_addr); end
        n_vec++; if (err_cnt !== 8'h0) begin n_bad++; $display("FAIL reset err_cnt got %h want 0", err_cnt); end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (a_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL idle a_rsp_valid got %b want 0", a_rsp_valid); end
    endtask

    task automatic test_word_load();
        vec_t v [7];
        rsp_t r;
        v = '{'{1'b1, 15'h10, 32'hDEADBEEF, 3'd0}, '{1'b0, 15'h13, 32'h0, 3'd3},
              '{1'b0, 15'h13, 32'h0, 3'd4},       '{1'b0, 15'h10, 32'h0, 3'd1},
              '{1'b0, 15'h10, 32'h0, 3'd0},       '{1'b0, 15'h12, 32'h0, 3'd2},
              '{1'b0, 15'h11, 32'h0, 3'd4}};
        for (int i = 0; i < 7; i++) begin
            drive(v[i]);
            @(posedge clk); #1;
            r = exp_q.pop_front();
            n_vec++;
            if ({a_rsp_valid, a_rsp_err, a_rdata} !== {1'b1, r.err, r.rdata}) begin
                n_bad++;
                $display("FAIL word_load[%0d] got v=%b e=%b d=%h want v=1 e=%b d=%h", i, a_rsp_valid, a_rsp_err, a_rdata, r.err, r.rdata);
            end
        end
        idle();
        @(posedge clk); #1;
        n_vec++;
        if ({a_rsp_valid, a_rdata} !== {1'b0, r.rdata}) begin
            n_bad++;
            $display("FAIL hold got v=%b d=%h want v=0 d=%h", a_rsp_valid, a_rdata, r.rdata);
        end
    endtask

    task automatic test_sub_store();
        vec_t v [8];
        rsp_t r;
        v = '{'{1'b1, 15'h20, 32'h11223344, 3'd0}, '{1'b1, 15'h21, 32'hAAAAAA7F, 3'd3},
              '{1'b0, 15'h20, 32'h0, 3'd0},        '{1'b0, 15'h22, 32'h0, 3'd2},
              '{1'b1, 15'h24, 32'h01020304, 3'd0}, '{1'b1, 15'h26, 32'hFFFFA5C3, 3'd1},
              '{1'b0, 15'h24, 32'h0, 3'd0},        '{1'b0, 15'h26, 32'h0, 3'd1}};
        for (int i = 0; i < 8; i++) begin
            drive(v[i]);
            @(posedge clk); #1;
            r = exp_q.pop_front();
            n_vec++;
            if ({a_rsp_valid, a_rsp_err, a_rdata} !== {1'b1, r.err, r.rdata}) begin
                n_bad++;
                $display("FAIL sub_store[%0d] got v=%b e=%b d=%h want v=1 e=%b d=%h", i, a_rsp_valid, a_rsp_err, a_rdata, r.err, r.rdata);
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        vec_t v;
        rsp_t r;
        for (int i = 0; i < 58; i++) begin
            if (i < 16) begin
                v = '{1'b1, 15'(i*4), $urandom, 3'd0};
            end else if (i == 16) begin
                v = '{1'b1, 15'h0, 32'h5A5AC3C3, 3'd0};
            end else if (i == 17) begin
                v = '{1'b0, 15'h0, 32'h0, 3'd0};
            end else begin
                v.we   = 1'($urandom_range(0, 1));
                v.mode = v.we ? 3'($urandom_range(0, 2) == 0 ? 0 : ($urandom_range(0, 1) ? 1 : 3))
                              : 3'($urandom_range(0, 4));
                v.addr = 15'($urandom_range(0, 63));
                if (v.mode == 3'd0) v.addr[1:0] = 2'b00;
                if (v.mode == 3'd1 || v.mode == 3'd2) v.addr[0] = 1'b0;
                v.wd = $urandom;
            end
            drive(v);
            @(posedge clk); #1;
            r = exp_q.pop_front();
            n_vec++;
            if ({a_rsp_valid, a_rsp_err, a_rdata} !== {1'b1, r.err, r.rdata}) begin
                n_bad++;
                $display("FAIL b2b[%0d] got v=%b e=%b d=%h want v=1 e=%b d=%h", i, a_rsp_valid, a_rsp_err, a_rdata, r.err, r.rdata);
            end
        end
        idle();
    endtask

    task automatic test_port_b();
        logic [31:0] old_w;
        logic [31:0] new_w;
        rsp_t        r;
        old_w  = {mdl[35], mdl[34], mdl[33], mdl[32]};
        new_w  = 32'h0BADCAFE;
        b_addr = 12'd8;
        drive('{1'b1, 15'h20, new_w, 3'd0});
        @(posedge clk); #1;
        idle();
        r = exp_q.pop_front();
        n_vec++;
        if ({a_rsp_valid, a_rsp_err, a_rdata} !== {1'b1, r.err, r.rdata}) begin
            n_bad++;
            $display("FAIL port_b store got v=%b e=%b d=%h want v=1 e=%b d=%h", a_rsp_valid, a_rsp_err, a_rdata, r.err, r.rdata);
        end
        n_vec++;
        if (b_rdata !== old_w) begin n_bad++; $display("FAIL port_b same_cycle got %h want %h", b_rdata, old_w); end
        @(posedge clk); #1;
        n_vec++;
        if (b_rdata !== new_w) begin n_bad++; $display("FAIL port_b next_cycle got %h want %h", b_rdata, new_w); end
        b_addr = 12'd4;
        @(posedge clk); #1;
        n_vec++;
        if (b_rdata !== {mdl[19], mdl[18], mdl[17], mdl[16]}) begin
            n_bad++;
            $display("FAIL port_b word4 got %h want %h", b_rdata, {mdl[19], mdl[18], mdl[17], mdl[16]});
        end
    endtask

    task automatic test_errors();
        vec_t v [7];
        rsp_t r;
        v = '{'{1'b1, 15'h2, 32'hFFFFFFFF, 3'd0},  '{1'b1, 15'h5, 32'hFFFFFFFF, 3'd1},
              '{1'b1, 15'h10, 32'hFFFFFFFF, 3'd6}, '{1'b1, 15'h8, 32'hFFFFFFFF, 3'd2},
              '{1'b0, 15'h0, 32'h0, 3'd0},         '{1'b0, 15'h4, 32'h0, 3'd0},
              '{1'b0, 15'h10, 32'h0, 3'd0}};
        for (int i = 0; i < 7; i++) begin
            drive(v[i]);
            @(posedge clk); #1;
            r = exp_q.pop_front();
            n_vec++;
            if ({a_rsp_valid, a_rsp_err, a_rdata} !== {1'b1, r.err, r.rdata}) begin
                n_bad++;
                $display("FAIL errors[%0d] got v=%b e=%b d=%h want v=1 e=%b d=%h", i, a_rsp_valid, a_rsp_err, a_rdata, r.err, r.rdata);
            end
            if (i == 2) begin
                n_vec++;
                if ({err_flag, err_addr, err_cnt} !== {1'b1, first_err_addr, 8'(n_errs)}) begin
                    n_bad++;
                    $display("FAIL err_book got f=%b a=%h c=%0d want f=1 a=%h c=%0d", err_flag, err_addr, err_cnt, first_err_addr, n_errs);
                end
            end
        end
        idle();
    endtask

    task automatic test_range();
        rsp_t r;
        int   exp_cnt;
        for (int i = 0; i < 262; i++) begin
            drive('{1'b0, 15'(DEPTH*4 + 4*$urandom_range(0, 4095)), 32'h0, 3'(i % 5)});
            @(posedge clk); #1;
            r = exp_q.pop_front();
            exp_cnt = (n_errs > 255) ? 255 : n_errs;
            n_vec++;
            if ({a_rsp_valid, a_rsp_err, a_rdata, err_cnt} !== {1'b1, r.err, r.rdata, 8'(exp_cnt)}) begin
                n_bad++;
                $display("FAIL range[%0d] got v=%b e=%b d=%h c=%0d want v=1 e=%b d=%h c=%0d", i, a_rsp_valid, a_rsp_err, a_rdata, err_cnt, r.err, r.rdata, exp_cnt);
            end
        end
        idle();
        @(posedge clk); #1;
        n_vec++;
        if ({a_rsp_valid, err_flag, err_addr, err_cnt} !== {1'b0, 1'b1, first_err_addr, 8'hFF}) begin
            n_bad++;
            $display("FAIL range_final got v=%b f=%b a=%h c=%0d want v=0 f=1 a=%h c=255", a_rsp_valid, err_flag, err_addr, err_cnt, first_err_addr);
        end
    endtask

    task automatic test_reset_mid();
        rsp_t r;
        drive('{1'b0, 15'h20, 32'h0, 3'd0});
        #2 rstn = 1'b0;
        @(posedge clk); #1;
        idle();
        exp_q.delete();
        n_errs = 0;
        have_err = 0;
        #1 rstn = 1'b1;
        #1;
        n_vec++;
        if ({a_rsp_valid, a_rsp_err, a_rdata, b_rdata, err_flag, err_addr, err_cnt} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid outputs got v=%b e=%b d=%h b=%h f=%b a=%h c=%0d want all 0", a_rsp_valid, a_rsp_err, a_rdata, b_rdata, err_flag, err_addr, err_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_vec++;
            if (a_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mid valid[%0d] got %b want 0", i, a_rsp_valid); end
        end
        drive('{1'b1, 15'h30, 32'hCAFEF00D, 3'd0});
        @(posedge clk); #1;
        idle();
        exp_q.delete();
        rstn = 1'b0;
        #2 rstn = 1'b1;
        #1;
        drive('{1'b0, 15'h30, 32'h0, 3'd0});
        @(posedge clk); #1;
        idle();
        r = exp_q.pop_front();
        n_vec++;
        if ({a_rsp_valid, a_rsp_err, a_rdata} !== {1'b1, r.err, r.rdata}) begin
            n_bad++;
            $display("FAIL store_survives got v=%b e=%b d=%h want v=1 e=%b d=%h", a_rsp_valid, a_rsp_err, a_rdata, r.err, r.rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: got no finish want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word_load();
        test_sub_store();
        test_back_to_back();
        test_port_b();
        test_errors();
        test_range();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
